// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Owns the PC, issues one 64-bit fetch at a
// time, presents two PC/instruction slots to the instruction queue, and
// sequences branch/CP0 redirects. A redirect that arrives while a response is
// still outstanding sends the FSM to DISCARD, which swallows that response.
// Optional macro FETCH_ALIGN_EN: fetch 8-byte aligned; an odd-word PC then
// yields only the upper half of the response, in slot 0.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             ireq_valid,
  output logic [31:0]      ireq_addr,
  input  logic             iresp_addr_ok,
  input  logic             iresp_data_ok,
  input  logic [63:0]      iresp_data,
  input  logic             queue_full,
  input  logic             br_redirect,
  input  logic [31:0]      br_target,
  input  logic             exc_redirect,
  input  logic [31:0]      exc_target,
  output logic [1:0]       out_valid,
  output logic [1:0][31:0] out_pc,
  output logic [1:0][31:0] out_instr
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} state_t;

  state_t            state, state_d;
  logic [31:0]       pc, pc_d;
  logic [1:0]        buf_valid;
  logic [1:0][31:0]  buf_pc, buf_instr;
  logic              ld_buf;

  logic              redir;
  logic [31:0]       tgt;
  logic [31:0]       fetch_addr, pc_seq;
  logic [1:0]        cap_valid;
  logic [1:0][31:0]  cap_pc, cap_instr;

  // Exception redirect wins over a simultaneous branch redirect.
  assign redir = exc_redirect | br_redirect;
  assign tgt   = exc_redirect ? exc_target : br_target;

  // Address issued and the buffer contents a response would produce.
  always_comb begin
    fetch_addr   = pc;
    pc_seq       = pc + 32'd8;
    cap_valid    = 2'b11;
    cap_pc[0]    = pc;
    cap_pc[1]    = pc + 32'd4;
    cap_instr[0] = iresp_data[31:0];
    cap_instr[1] = iresp_data[63:32];
`ifdef FETCH_ALIGN_EN
    fetch_addr = {pc[31:3], 3'b000};
    if (pc[2]) begin
      // Odd-word PC: the low half belongs to the previous word, drop it.
      pc_seq       = fetch_addr + 32'd8;
      cap_valid    = 2'b01;
      cap_pc[1]    = 32'd0;
      cap_instr[0] = iresp_data[63:32];
      cap_instr[1] = 32'd0;
    end
`endif
  end

  // Next-state, PC update and bus/queue outputs.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ld_buf     = 1'b0;
    ireq_valid = 1'b0;
    ireq_addr  = 32'd0;
    out_valid  = 2'b00;
    out_pc     = '0;
    out_instr  = '0;
    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        ireq_valid = 1'b1;
        ireq_addr  = fetch_addr;
        if (redir) pc_d = tgt;
        if (iresp_addr_ok) state_d = redir ? DISCARD : WAIT;
      end
      WAIT: begin
        if (iresp_data_ok) begin
          if (redir) begin
            pc_d    = tgt;
            state_d = REQ;
          end else begin
            ld_buf  = 1'b1;
            pc_d    = pc_seq;
            state_d = HOLD;
          end
        end else if (redir) begin
          pc_d    = tgt;
          state_d = DISCARD;
        end
      end
      HOLD: begin
        out_pc    = buf_pc;
        out_instr = buf_instr;
        if (redir) begin
          pc_d    = tgt;
          state_d = REQ;
        end else begin
          out_valid = buf_valid;
          if (!queue_full) state_d = REQ;
        end
      end
      DISCARD: begin
        if (redir) pc_d = tgt;
        if (iresp_data_ok) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and slot buffer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      buf_valid <= 2'b00;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (ld_buf) begin
        buf_valid <= cap_valid;
        buf_pc    <= cap_pc;
        buf_instr <= cap_instr;
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer that owns the program counter and drives the instruction bus. It issues one 64-bit fetch per request, returns two PC/instruction slots to the instruction queue, and sequences redirects from branch resolution and CP0 (exception/eret). It sits between the I-cache bus interface and the instruction queue, and replaces ad-hoc flush tokens with an explicit discard state.

## Interface
- RESET_PC, 32'hbfc0_0000, first fetch address after reset
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  reset, asynchronous, active-low
- ireq_valid  out  1  fetch request valid
- ireq_addr  out  32  fetch address
- iresp_addr_ok  in  1  request accepted this cycle (meaningful only with ireq_valid)
- iresp_data_ok  in  1  response data valid this cycle
- iresp_data  in  64  [31:0] = instr at addr, [63:32] = instr at addr+4
- queue_full  in  1  instruction queue cannot accept a push this cycle
- br_redirect  in  1  branch mispredict/taken redirect pulse
- br_target  in  32  branch target
- exc_redirect  in  1  CP0 flush/eret redirect pulse
- exc_target  in  32  exception vector or EPC
- out_valid  out  2  per-slot valid, pushed when out_valid!=0 && !queue_full
- out_pc  out  2x32  slot PCs
- out_instr  out  2x32  slot instructions

## Operation
- Registers: pc (32), state, buffer {valid[1:0], pc[1:0], instr[1:0]}.
- States: IDLE, REQ, WAIT, HOLD, DISCARD.
- Redirect target: exc_target if exc_redirect, else br_target (exception wins on simultaneous pulses).
- IDLE: entered only by reset; next cycle -> REQ.
- REQ: ireq_valid=1, ireq_addr=pc. addr_ok && no redirect -> WAIT. addr_ok && redirect -> pc<=target, DISCARD. Redirect without addr_ok -> pc<=target, stay REQ (address may change before acceptance).
- WAIT: data_ok && no redirect -> capture buffer (pc, pc+4, data halves, valid=2'b11), pc<=pc+8, HOLD. data_ok && redirect -> drop data, pc<=target, REQ. Redirect without data_ok -> pc<=target, DISCARD.
- HOLD: out_* driven from buffer. !queue_full -> push, -> REQ. Redirect -> buffer dropped (out_valid forced 0 that cycle), pc<=target, REQ.
- DISCARD: waits for the in-flight response; data_ok -> drop, REQ. Further redirect -> pc<=newest target.
- Max one outstanding request; ireq_valid=0 outside REQ.
- Arithmetic: PC increments mod 2^32, wrap at 32'hffff_fff8 -> 0 with no error.

## Timing
- Reset (async assert): state=IDLE, pc=RESET_PC, buffer cleared; ireq_valid=0, ireq_addr=0 outside REQ, out_valid=0, out_pc=0, out_instr=0.
- First ireq_valid: second posedge after resetn deasserts (IDLE, then REQ).
- Latency: addr_ok at cycle t, data_ok at t+k (k>=1) -> out_valid at t+k+1.
- Best case throughput: one fetch per 3 cycles (REQ, WAIT, HOLD); no overlap by design.
- ireq_addr stable in REQ except on the redirect cycle.
- out_* stable throughout HOLD; out_valid=0 in every other state.

## Configuration
- FETCH_ALIGN_EN defined: ireq_addr={pc[31:3],3'b0}. If pc[2]=1, only iresp_data[63:32] is used, placed in slot 0 with out_pc[0]=pc, valid=2'b01, next pc=aligned+8. If pc[2]=0, behaviour is unchanged.
- Undefined: ireq_addr=pc unaligned-to-8 allowed, always valid=2'b11, next pc=pc+8.

## Test plan
- Reset release, addr_ok immediate, data_ok 1 cycle later with data 64'h2222_2222_1111_1111 -> out_pc={bfc00004,bfc00000}, out_instr={22222222,11111111}, valid 2'b11; next ireq_addr=bfc00008.
- queue_full held 3 cycles during HOLD -> out_* stable 3 cycles, single push when queue_full drops, then REQ.
- br_redirect (target 8000_0100) in WAIT -> DISCARD; next data_ok produces no out_valid; following ireq_addr=8000_0100.
- Simultaneous exc_redirect (bfc0_0380) and br_redirect (8000_0100) in REQ without addr_ok -> ireq_addr=bfc0_0380 next cycle.
- resetn asserted mid-WAIT -> all outputs 0 immediately; late data_ok after release ignored; first fetch at RESET_PC.
- FETCH_ALIGN_EN, redirect to 8000_0104 -> ireq_addr=8000_0100, valid 2'b01, out_pc[0]=8000_0104, out_instr[0]=data[63:32], next ireq_addr=8000_0108.
